// File: rtl/vta_gmem_pkg.sv
// Shared AXI constants and the default DRAM window base for the gmem limiter.
package vta_gmem_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [63:0] VTA_GMEM_BASE_ADDR = 64'h20_0000_0000;

    localparam int unsigned OUT_CNT_W = 8;

endpackage

// File: rtl/vta_gmem_out_counter.sv
// Outstanding-burst counter: +1 on request accept, -1 on completion, floors at 0.
// Also provides a full flag and a zero flag taken from the next-state value.
module vta_gmem_out_counter
    import vta_gmem_pkg::*;
#(
    parameter int unsigned MAX = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [OUT_CNT_W-1:0] cnt_o,
    output logic                 full_o,
    output logic                 nxt_zero_o
);

    localparam logic [OUT_CNT_W-1:0] MAX_C = OUT_CNT_W'(MAX);

    logic [OUT_CNT_W-1:0] cnt_q;
    logic [OUT_CNT_W-1:0] cnt_d;

    // A completion with nothing outstanding is a stray from before reset: ignore it.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign full_o     = (cnt_q == MAX_C);
    assign nxt_zero_o = (cnt_d == '0);

endmodule

// File: rtl/vta_gmem_txn_limiter.sv
// gmem shim: rebases AR/AW into the DRAM window, caps outstanding bursts, drain/idle handshake.
// Optional sticky R/B error flags are built when VTA_GMEM_RESP_CHECK_EN is defined.
module vta_gmem_txn_limiter
    import vta_gmem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       ID_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = VTA_GMEM_BASE_ADDR[ADDR_W-1:0],
    parameter int unsigned       MAX_RD_OUT = 8,
    parameter int unsigned       MAX_WR_OUT = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
`ifdef VTA_GMEM_RESP_CHECK_EN
    output logic [1:0]           err_sticky,
`endif
    input  logic                 drain_req,
    output logic                 idle,
    output logic [OUT_CNT_W-1:0] rd_out_cnt,
    output logic [OUT_CNT_W-1:0] wr_out_cnt,
    // AR
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ADDR_W-1:0]    s_araddr,
    input  logic [ID_W-1:0]      s_arid,
    input  logic [7:0]           s_arlen,
    input  logic [2:0]           s_arsize,
    input  logic [1:0]           s_arburst,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    output logic [ADDR_W-1:0]    m_araddr,
    output logic [ID_W-1:0]      m_arid,
    output logic [7:0]           m_arlen,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    // R
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [DATA_W-1:0]    s_rdata,
    output logic                 s_rlast,
    output logic [ID_W-1:0]      s_rid,
    output logic [1:0]           s_rresp,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    input  logic [DATA_W-1:0]    m_rdata,
    input  logic                 m_rlast,
    input  logic [ID_W-1:0]      m_rid,
    input  logic [1:0]           m_rresp,
    // AW
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic [ID_W-1:0]      s_awid,
    input  logic [7:0]           s_awlen,
    input  logic [2:0]           s_awsize,
    input  logic [1:0]           s_awburst,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [ADDR_W-1:0]    m_awaddr,
    output logic [ID_W-1:0]      m_awid,
    output logic [7:0]           m_awlen,
    output logic [2:0]           m_awsize,
    output logic [1:0]           m_awburst,
    // W
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [DATA_W-1:0]    s_wdata,
    input  logic [DATA_W/8-1:0]  s_wstrb,
    input  logic                 s_wlast,
    output logic                 m_wvalid,
    input  logic                 m_wready,
    output logic [DATA_W-1:0]    m_wdata,
    output logic [DATA_W/8-1:0]  m_wstrb,
    output logic                 m_wlast,
    // B
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    output logic [ID_W-1:0]      s_bid,
    input  logic                 m_bvalid,
    output logic                 m_bready,
    input  logic [1:0]           m_bresp,
    input  logic [ID_W-1:0]      m_bid
);

    logic rd_full, wr_full;
    logic rd_nxt_zero, wr_nxt_zero;
    logic rd_block, wr_block;
    logic ar_hs, aw_hs, r_hs, r_last_hs, b_hs;
    logic idle_q;

    assign rd_block = drain_req | rd_full;
    assign wr_block = drain_req | wr_full;

    assign m_arvalid = s_arvalid & ~rd_block;
    assign s_arready = m_arready & ~rd_block;
    assign m_araddr  = s_araddr + BASE_ADDR;
    assign m_arid    = s_arid;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;

    assign m_awvalid = s_awvalid & ~wr_block;
    assign s_awready = m_awready & ~wr_block;
    assign m_awaddr  = s_awaddr + BASE_ADDR;
    assign m_awid    = s_awid;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;

    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_rdata  = m_rdata;
    assign s_rlast  = m_rlast;
    assign s_rid    = m_rid;
    assign s_rresp  = m_rresp;

    // W may legally lead its AW, so it is never held back by the write limit.
    assign m_wvalid = s_wvalid;
    assign s_wready = m_wready;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
    assign m_wlast  = s_wlast;

    assign s_bvalid = m_bvalid;
    assign m_bready = s_bready;
    assign s_bresp  = m_bresp;
    assign s_bid    = m_bid;

    assign ar_hs     = s_arvalid & s_arready;
    assign aw_hs     = s_awvalid & s_awready;
    assign r_hs      = m_rvalid & s_rready;
    assign r_last_hs = r_hs & m_rlast;
    assign b_hs      = m_bvalid & s_bready;

    vta_gmem_out_counter #(.MAX(MAX_RD_OUT)) u_rd_cnt (
        .clk_i      (ap_clk),
        .rst_n_i    (ap_rst_n),
        .inc_i      (ar_hs),
        .dec_i      (r_last_hs),
        .cnt_o      (rd_out_cnt),
        .full_o     (rd_full),
        .nxt_zero_o (rd_nxt_zero)
    );

    vta_gmem_out_counter #(.MAX(MAX_WR_OUT)) u_wr_cnt (
        .clk_i      (ap_clk),
        .rst_n_i    (ap_rst_n),
        .inc_i      (aw_hs),
        .dec_i      (b_hs),
        .cnt_o      (wr_out_cnt),
        .full_o     (wr_full),
        .nxt_zero_o (wr_nxt_zero)
    );

    // idle tracks the counters with no extra lag by sampling their next-state values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idle_q <= 1'b1;
        end else begin
            idle_q <= rd_nxt_zero & wr_nxt_zero;
        end
    end

    assign idle = idle_q;

`ifdef VTA_GMEM_RESP_CHECK_EN
    logic [1:0] err_q, err_d;

    // resp[1] set covers both SLVERR and DECERR.
    always_comb begin
        err_d = err_q;
        if (r_hs && m_rresp[1]) err_d[0] = 1'b1;
        if (b_hs && m_bresp[1]) err_d[1] = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule
